// File: rtl/stream_fifo_pkg.sv
// Shared sizing helpers for the stream_fifo block.
// Both the level and pointer widths depend on parameters, so they are
// computed once here and reused by every file of the block.

package stream_fifo_pkg;

    // Bits needed to hold a fill level in the range 0..cap inclusive.
    function automatic int level_width(input int cap);
        return $clog2(cap + 1);
    endfunction

    // Bits needed for a storage pointer over depth entries, never less than one.
    function automatic int ptr_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : stream_fifo_pkg

// File: rtl/stream_fifo_if.sv
// Valid/ready stream channel used on both sides of stream_fifo.
// The master drives valid and data; the slave drives ready.

interface stream_fifo_if #(
    parameter int WIDTH = 32
) ();

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    // Producer side of the channel.
    modport master (
        output valid,
        output data,
        input  ready
    );

    // Consumer side of the channel.
    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface : stream_fifo_if

// File: rtl/stream_fifo_oreg.sv
// One-entry valid/ready register slice placed after the storage array.
// It breaks the path from the array read port to m_data. It accepts a new
// word whenever it is empty or its current word is being taken, so
// back-to-back traffic still moves at one beat per cycle.

module stream_fifo_oreg #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;

    // The slice can take a word when it is empty or being drained this cycle.
    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Next occupancy: refill from the array whenever a slot is free.
    always_comb begin
        valid_d = valid_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
        end
    end

    // Occupancy flag; both reset and flush drop any word held here.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data capture; the payload needs no reset because valid_q qualifies it.
    always_ff @(posedge clk_i) begin
        if (in_valid_i && in_ready_o) begin
            data_q <= in_data_i;
        end
    end

endmodule : stream_fifo_oreg

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO with valid/ready on both sides.
// Storage, pointers and the occupancy counter live here. An optional
// register slice adds one extra entry and one extra cycle of latency in
// exchange for a registered m_data. Every status output is decoded from
// the count register alone, so no flag depends combinationally on
// s_valid or m_ready.

module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int OUT_REG  = 0
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   flush_i,
    stream_fifo_if.slave                           s_if,
    stream_fifo_if.master                          m_if,
    output logic [level_width(DEPTH+OUT_REG)-1:0]  level_o,
    output logic                                   full_o,
    output logic                                   empty_o,
    output logic                                   almost_full_o,
    output logic                                   almost_empty_o
);

    localparam int CAP = DEPTH + OUT_REG;
    localparam int LW  = level_width(CAP);
    localparam int PW  = ptr_width(DEPTH);

    localparam logic [LW-1:0] CAP_L = LW'(CAP);
    localparam logic [LW-1:0] AF_L  = LW'(AF_LEVEL);
    localparam logic [LW-1:0] AE_L  = LW'(AE_LEVEL);
    localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);

    // Reject parameter sets that would make the flags or storage meaningless.
    if (DEPTH < 2) begin : g_chk_depth
        $error("stream_fifo: DEPTH must be at least 2");
    end
    if (AF_LEVEL > CAP) begin : g_chk_af
        $error("stream_fifo: AF_LEVEL must not exceed the capacity");
    end
    if (AE_LEVEL >= CAP) begin : g_chk_ae
        $error("stream_fifo: AE_LEVEL must be below the capacity");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    rd_ptr_d;
    logic [LW-1:0]    count_q;
    logic [LW-1:0]    count_d;

    logic             s_ready;
    logic             m_valid;
    logic             push;
    logic             pop;
    logic             arr_pop;

    // Advance a storage pointer, wrapping from the last entry back to zero.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Status decode: all of it comes straight off the count register.
    assign full_o         = (count_q == CAP_L);
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (count_q >= AF_L);
    assign almost_empty_o = (count_q <= AE_L);
    assign level_o        = count_q;

    // A full FIFO refuses writes even when a pop lands in the same cycle,
    // which keeps m_ready out of the s_ready path.
    assign s_ready    = !full_o;
    assign s_if.ready = s_ready;
    assign m_if.valid = m_valid;

    assign push = s_if.valid && s_ready;
    assign pop  = m_valid && m_if.ready;

    if (OUT_REG != 0) begin : g_oreg
        logic [LW-1:0] arr_cnt;
        logic          arr_valid;
        logic          oreg_ready;

        // Words in the array are the total count minus the one in the slice.
        assign arr_cnt   = count_q - LW'(m_valid);
        assign arr_valid = (arr_cnt != '0);
        assign arr_pop   = arr_valid && oreg_ready;

        stream_fifo_oreg #(
            .WIDTH (WIDTH)
        ) u_oreg (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .flush_i     (flush_i),
            .in_valid_i  (arr_valid),
            .in_ready_o  (oreg_ready),
            .in_data_i   (mem_q[rd_ptr_q]),
            .out_valid_o (m_valid),
            .out_ready_i (m_if.ready),
            .out_data_o  (m_if.data)
        );
    end else begin : g_direct
        // Fall-through: the array head is presented as soon as it is written.
        assign m_valid   = !empty_o;
        assign m_if.data = mem_q[rd_ptr_q];
        assign arr_pop   = pop;
    end

    // Next-state for pointers and count; flush returns them to their reset values.
    // NOTE: every output gets a default first so no path through the
    // block leaves a variable unassigned, which would infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (arr_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + LW'(1);
                2'b01:   count_d = count_q - LW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    // NOTE: non-blocking assignments make every register in this block
    // update together at the edge, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port.
    // NOTE: the array is deliberately left out of reset; count_q and the
    // pointers decide which entries are meaningful, so clearing it adds
    // nothing and would prevent mapping onto RAM.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_if.data;
        end
    end

    level_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= CAP_L);

    no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && full_o));

    no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(pop && empty_o));

endmodule : stream_fifo

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo. Two instances run side by side:
// dut0 is DEPTH=4, OUT_REG=0 and dut1 is DEPTH=4, OUT_REG=1. Directed
// stimulus feeds both; a monitor keeps one scoreboard queue per instance,
// filled when a write is accepted and drained when the DUT presents a beat.

module tb_stream_fifo;

    localparam int W      = 32;
    localparam int CAP0   = 4;
    localparam int CAP1   = 5;
    localparam int AF_LVL = 3;
    localparam int AE_LVL = 1;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    logic flush0;
    logic flush1;

    logic [2:0] level0;
    logic [2:0] level1;
    logic full0, empty0, af0, ae0;
    logic full1, empty1, af1, ae1;

    stream_fifo_if #(.WIDTH(W)) s0_if ();
    stream_fifo_if #(.WIDTH(W)) m0_if ();
    stream_fifo_if #(.WIDTH(W)) s1_if ();
    stream_fifo_if #(.WIDTH(W)) m1_if ();

    stream_fifo #(
        .WIDTH(W), .DEPTH(4), .AF_LEVEL(AF_LVL), .AE_LEVEL(AE_LVL), .OUT_REG(0)
    ) dut0 (
        .clk_i          (clk),
        .rst_i          (rst0),
        .flush_i        (flush0),
        .s_if           (s0_if),
        .m_if           (m0_if),
        .level_o        (level0),
        .full_o         (full0),
        .empty_o        (empty0),
        .almost_full_o  (af0),
        .almost_empty_o (ae0)
    );

    stream_fifo #(
        .WIDTH(W), .DEPTH(4), .AF_LEVEL(AF_LVL), .AE_LEVEL(AE_LVL), .OUT_REG(1)
    ) dut1 (
        .clk_i          (clk),
        .rst_i          (rst1),
        .flush_i        (flush1),
        .s_if           (s1_if),
        .m_if           (m1_if),
        .level_o        (level1),
        .full_o         (full1),
        .empty_o        (empty1),
        .almost_full_o  (af1),
        .almost_empty_o (ae1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] sb0 [$];
    logic [W-1:0] sb1 [$];
    int           pops [2];
    logic         hold [2];
    logic [W-1:0] hold_data [2];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One monitor step for one instance, evaluated on the falling edge with
    // the inputs that the next rising edge will act on.
    task automatic mon(input int id, input logic rst, input logic flush,
                       input logic s_valid, input logic s_ready, input logic [W-1:0] s_data,
                       input logic m_valid, input logic m_ready, input logic [W-1:0] m_data,
                       input logic [2:0] level, input logic full, input logic empty,
                       input logic af, input logic ae, input int cap, input bit direct);
        int           sz;
        logic         push;
        logic         pop;
        logic [W-1:0] front;
        string        p;
        p  = $sformatf("d%0d.", id);
        sz = (id == 0) ? sb0.size() : sb1.size();
        if (rst) begin
            if (id == 0) sb0.delete(); else sb1.delete();
            hold[id] = 1'b0;
            return;
        end
        check({p, "level"},    W'(level),   W'(sz));
        check({p, "full"},     W'(full),    W'(sz == cap));
        check({p, "empty"},    W'(empty),   W'(sz == 0));
        check({p, "alm_full"}, W'(af),      W'(sz >= AF_LVL));
        check({p, "alm_empty"},W'(ae),      W'(sz <= AE_LVL));
        check({p, "s_ready"},  W'(s_ready), W'(sz < cap));
        if (direct) begin
            check({p, "m_valid"}, W'(m_valid), W'(sz != 0));
        end
        if (hold[id]) begin
            check({p, "hold_valid"}, W'(m_valid), 1);
            check({p, "hold_data"},  m_data, hold_data[id]);
        end
        push = s_valid && (sz < cap);
        pop  = m_valid && m_ready;
        if (pop) begin
            check({p, "pop_has_entry"}, W'(sz != 0), 1);
            if (sz != 0) begin
                front = (id == 0) ? sb0.pop_front() : sb1.pop_front();
                check({p, "m_data"}, m_data, front);
                pops[id]++;
            end
        end
        if (flush) begin
            if (id == 0) sb0.delete(); else sb1.delete();
            hold[id] = 1'b0;
        end else begin
            if (push) begin
                if (id == 0) sb0.push_back(s_data); else sb1.push_back(s_data);
            end
            hold[id]      = m_valid && !m_ready;
            hold_data[id] = m_data;
        end
    endtask

    // Monitor process: runs independently of the stimulus below.
    always @(negedge clk) begin
        mon(0, rst0, flush0, s0_if.valid, s0_if.ready, s0_if.data,
            m0_if.valid, m0_if.ready, m0_if.data, level0, full0, empty0, af0, ae0, CAP0, 1'b1);
        mon(1, rst1, flush1, s1_if.valid, s1_if.ready, s1_if.data,
            m1_if.valid, m1_if.ready, m1_if.data, level1, full1, empty1, af1, ae1, CAP1, 1'b0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic d0(input logic v, input logic [W-1:0] d, input logic r);
        s0_if.valid = v;
        s0_if.data  = d;
        m0_if.ready = r;
        step();
    endtask

    task automatic d1(input logic v, input logic [W-1:0] d, input logic r);
        s1_if.valid = v;
        s1_if.data  = d;
        m1_if.ready = r;
        step();
    endtask

    // Level sweep 0->4->0 with the flag values expected after each handshake.
    int   sweep_lvl [8] = '{1, 2, 3, 4, 3, 2, 1, 0};
    logic sweep_af  [8] = '{0, 0, 1, 1, 1, 0, 0, 0};
    logic sweep_ae  [8] = '{1, 0, 0, 0, 0, 0, 1, 1};

    initial begin
        int cyc;
        int base;
        pops[0] = 0; pops[1] = 0;
        hold[0] = 1'b0; hold[1] = 1'b0;
        s0_if.valid = 1'b0; s0_if.data = '0; m0_if.ready = 1'b0;
        s1_if.valid = 1'b0; s1_if.data = '0; m1_if.ready = 1'b0;
        flush0 = 1'b0; flush1 = 1'b0;
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (2) step();
        rst0 = 1'b0; rst1 = 1'b0;

        // Reset values on both instances.
        check("rst.level0",   W'(level0), 0);
        check("rst.empty0",   W'(empty0), 1);
        check("rst.full0",    W'(full0), 0);
        check("rst.m_valid0", W'(m0_if.valid), 0);
        check("rst.s_ready0", W'(s0_if.ready), 1);
        check("rst.ae0",      W'(ae0), 1);
        check("rst.af0",      W'(af0), 0);
        check("rst.m_valid1", W'(m1_if.valid), 0);
        check("rst.s_ready1", W'(s1_if.ready), 1);

        // Fill to capacity with the consumer stalled, then drain.
        for (int i = 0; i < 4; i++) d0(1'b1, W'(32'hA0 + i), 1'b0);
        check("fill.full",    W'(full0), 1);
        check("fill.s_ready", W'(s0_if.ready), 0);
        check("fill.level",   W'(level0), 4);
        check("fill.head",    m0_if.data, 32'hA0);
        d0(1'b1, 32'hA4, 1'b0);
        check("fill.fifth_refused", W'(level0), 4);
        for (int i = 0; i < 4; i++) d0(1'b0, '0, 1'b1);
        check("drain.empty", W'(empty0), 1);

        // Pointer wrap with three entries held and steady push/pop pairs.
        for (int i = 0; i < 3; i++) d0(1'b1, W'(32'hB0 + i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            d0(1'b1, W'(32'hC0 + i), 1'b1);
            check("wrap.level", W'(level0), 3);
        end
        check("wrap.head", m0_if.data, 32'hC7);
        for (int i = 0; i < 3; i++) d0(1'b0, '0, 1'b1);
        check("wrap.empty", W'(empty0), 1);

        // Simultaneous push and pop at level 1.
        d0(1'b1, 32'hD0, 1'b0);
        d0(1'b1, 32'hD1, 1'b1);
        check("pp1.level",   W'(level0), 1);
        check("pp1.m_valid", W'(m0_if.valid), 1);
        check("pp1.m_data",  m0_if.data, 32'hD1);
        d0(1'b0, '0, 1'b1);

        // Simultaneous push and pop at level 4: only the pop happens.
        for (int i = 0; i < 4; i++) d0(1'b1, W'(32'hE0 + i), 1'b0);
        d0(1'b1, 32'hE4, 1'b1);
        check("pp4.level",  W'(level0), 3);
        check("pp4.m_data", m0_if.data, 32'hE1);
        for (int i = 0; i < 3; i++) d0(1'b0, '0, 1'b1);

        // Simultaneous push and pop at level 0: only the push happens.
        d0(1'b1, 32'hF0, 1'b1);
        check("pp0.level",   W'(level0), 1);
        check("pp0.m_valid", W'(m0_if.valid), 1);
        check("pp0.m_data",  m0_if.data, 32'hF0);
        d0(1'b0, '0, 1'b1);
        check("pp0.empty", W'(empty0), 1);

        // Threshold sweep.
        for (int k = 0; k < 8; k++) begin
            if (k < 4) d0(1'b1, W'(32'h40 + k), 1'b0);
            else       d0(1'b0, '0, 1'b1);
            check($sformatf("sweep%0d.level", k), W'(level0), W'(sweep_lvl[k]));
            check($sformatf("sweep%0d.af", k),    W'(af0),    W'(sweep_af[k]));
            check($sformatf("sweep%0d.ae", k),    W'(ae0),    W'(sweep_ae[k]));
        end

        // Flush at level 3 with a concurrent write.
        for (int i = 0; i < 3; i++) d0(1'b1, W'(32'h60 + i), 1'b0);
        flush0 = 1'b1;
        d0(1'b1, 32'h63, 1'b0);
        flush0 = 1'b0;
        check("flush.level",   W'(level0), 0);
        check("flush.empty",   W'(empty0), 1);
        check("flush.m_valid", W'(m0_if.valid), 0);
        check("flush.s_ready", W'(s0_if.ready), 1);
        d0(1'b1, 32'h77, 1'b0);
        check("flush.next_word", m0_if.data, 32'h77);
        d0(1'b0, '0, 1'b1);
        check("flush.sb_empty", W'(sb0.size()), 0);

        // Registered output: two-cycle first-data latency.
        d1(1'b1, 32'h11, 1'b0);
        check("lat.m_valid_c1", W'(m1_if.valid), 0);
        check("lat.level_c1",   W'(level1), 1);
        d1(1'b0, '0, 1'b0);
        check("lat.m_valid_c2", W'(m1_if.valid), 1);
        check("lat.m_data_c2",  m1_if.data, 32'h11);
        d1(1'b0, '0, 1'b1);
        check("lat.empty", W'(empty1), 1);

        // Registered output: capacity of DEPTH+1 and stable data under stall.
        for (int i = 0; i < 5; i++) d1(1'b1, W'(32'h20 + i), 1'b0);
        check("cap.level",   W'(level1), 5);
        check("cap.full",    W'(full1), 1);
        check("cap.s_ready", W'(s1_if.ready), 0);
        d1(1'b1, 32'h25, 1'b0);
        check("cap.sixth_refused", W'(level1), 5);
        repeat (3) d1(1'b0, '0, 1'b0);
        check("cap.stall_data", m1_if.data, 32'h20);
        for (int i = 0; i < 5; i++) d1(1'b0, '0, 1'b1);
        check("cap.empty", W'(empty1), 1);

        // Random valid/ready traffic; the monitor checks order and content.
        base = pops[1];
        cyc  = 0;
        while ((pops[1] - base) < 2000 && cyc < 20000) begin
            d1($urandom_range(0, 9) < 7, 32'h1000_0000 + W'(cyc), $urandom_range(0, 9) < 6);
            cyc++;
        end
        check("rand.beats_done", W'((pops[1] - base) >= 2000), 1);
        for (int i = 0; i < 8; i++) d1(1'b0, '0, 1'b1);
        check("rand.sb_empty", W'(sb1.size()), 0);
        check("rand.empty",    W'(empty1), 1);

        // Reset in the middle of a transfer.
        d1(1'b1, 32'h30, 1'b0);
        d1(1'b1, 32'h31, 1'b1);
        rst1 = 1'b1;
        d1(1'b1, 32'h32, 1'b1);
        rst1 = 1'b0;
        check("mrst.level",   W'(level1), 0);
        check("mrst.empty",   W'(empty1), 1);
        check("mrst.full",    W'(full1), 0);
        check("mrst.m_valid", W'(m1_if.valid), 0);
        check("mrst.s_ready", W'(s1_if.ready), 1);
        check("mrst.ae",      W'(ae1), 1);
        check("mrst.af",      W'(af1), 0);
        d1(1'b0, '0, 1'b0);
        check("mrst.no_stale", W'(m1_if.valid), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_stream_fifo

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Parametrised synchronous FIFO with valid/ready handshakes on both the write and read sides.
- It is first-word-fall-through and reports its fill level and programmable almost-full / almost-empty flags.
- It has a synchronous flush and an optional registered output stage for timing closure.
- It sits between stream producers and consumers in the accelerator datapath, for example the AXI-Stream ingress to the FIR engine.

Parameters:
- WIDTH, 32: data width in bits.
- DEPTH, 4: number of storage entries; any integer ≥ 2, power of two not required.
- AF_LEVEL, DEPTH-1: almost_full asserts when level ≥ AF_LEVEL.
- AE_LEVEL, 1: almost_empty asserts when level ≤ AE_LEVEL.
- OUT_REG, 0: 1 adds a registered output stage. Total capacity becomes DEPTH+1 and first-data latency becomes 2 cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all contents.
- s_valid  in  1  write data valid.
- s_ready  out  1  FIFO can accept a write.
- s_data  in  WIDTH  write data.
- m_valid  out  1  read data valid.
- m_ready  in  1  consumer accepts read data.
- m_data  out  WIDTH  read data, head of queue.
- level  out  LW  entries held. LW = $clog2(CAP+1), where CAP = DEPTH+OUT_REG.
- full  out  1  level == CAP.
- empty  out  1  level == 0.
- almost_full  out  1  level ≥ AF_LEVEL.
- almost_empty  out  1  level ≤ AE_LEVEL.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values:
  - level=0, empty=1, full=0, m_valid=0, s_ready=1.
  - almost_empty=1. almost_full=(AF_LEVEL==0).
  - Pointers are 0.
  - Storage array is not reset. m_data is don't-care while m_valid=0.
- Handshakes:
  - push = s_valid & s_ready.
  - pop = m_valid & m_ready.
  - s_ready = !full, registered-equivalent. It has no combinational path from m_ready, so a write is refused when the FIFO is full even if a pop happens in the same cycle.
  - m_valid = !empty for OUT_REG=0.
  - m_data and m_valid must hold stable while m_valid & !m_ready.
- Latency, OUT_REG=0: a push into an empty FIFO gives m_valid=1 with that data on the next cycle.
- Latency, OUT_REG=1:
  - Array head is loaded into the output register whenever the register is empty or being popped. This gives 2 cycles of push-to-m_valid latency.
  - Throughput remains 1 beat/cycle at steady state.
- Pointers:
  - wr_ptr and rd_ptr each wrap from DEPTH-1 to 0.
  - Width is $clog2(DEPTH), minimum 1.
  - Status is derived from an explicit count register, not from pointer comparison.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push & pop.
  - A simultaneous push & pop when level==1 (OUT_REG=0) keeps m_valid=1 and presents the new word next cycle.
- Flags: full, empty, almost_* and level are all functions of the count register. They change in the cycle after the causing handshake and have no combinational dependency on s_valid or m_ready.
- flush:
  - Takes priority over push and pop in the same cycle. A concurrent push is discarded.
  - Next cycle the state equals the reset state, except storage contents.
- rst overrides flush.
- Reset or flush mid-transfer: any beat not yet popped is lost. No partial state may remain; the output register is also invalidated.
- Underflow and overflow are impossible by construction. Assertions check that level never exceeds CAP and never goes negative.
- Elaboration checks: error if DEPTH < 2, AF_LEVEL > CAP, or AE_LEVEL ≥ CAP.

Decomposition:
- Package stream_fifo_pkg holds:
  - function level_width(cap), returning $clog2(cap+1);
  - function ptr_width(depth), returning max(1, $clog2(depth)).
- Sub-module stream_fifo_oreg: a one-entry valid/ready register slice, instantiated under a generate block when OUT_REG=1.
- Storage, pointers and count live in the top level.

Test Plan:
1. Fill/drain, DEPTH=4, OUT_REG=0. Push 0xA0..0xA3 with m_ready=0 → full=1 and s_ready=0 after the 4th push, level=4. A 5th s_valid is not accepted. Raise m_ready → A0..A3 out in order, then empty=1.
2. Wrap-around. Run 10 push/pop pairs with 3 entries pre-filled → output order matches input across pointer wrap 3→0, and level stays 3 throughout.
3. Simultaneous push & pop at level 1, level 4 and level 0:
   - level 1 → level stays 1;
   - level 4 → only the pop occurs, level becomes 3;
   - level 0 → only the push occurs, m_valid is 1 next cycle.
4. Thresholds AF_LEVEL=3, AE_LEVEL=1. Step level 0→4→0 → almost_full is high exactly at levels 3–4 and almost_empty is high exactly at levels 0–1, each updating one cycle after the handshake.
5. Flush with level=3 and s_valid=1 in the same cycle → next cycle level=0, empty=1, m_valid=0. The pushed word is never output.
6. OUT_REG=1, DEPTH=4:
   - Random s_valid and m_ready over 2000 beats against a scoreboard → no loss, duplication or reorder.
   - Capacity reaches 5 entries.
   - First-data latency is 2 cycles.
   - m_data is stable during backpressure.
   - rst asserted mid-stream gives reset values on the next cycle.
